// File: rtl/pcm_stream_pkg.sv
// Shared register map, CTRL/STATUS bit positions and reset defaults for the PCM stream FIFO.
package pcm_stream_pkg;

  localparam logic [3:0] REG_DATA     = 4'h0;
  localparam logic [3:0] REG_CTRL     = 4'h4;
  localparam logic [3:0] REG_LOWWATER = 4'h8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_CLR_BIT   = 2;

  localparam int ST_EMPTY_BIT    = 16;
  localparam int ST_FULL_BIT     = 17;
  localparam int ST_UNDERRUN_BIT = 18;
  localparam int ST_OVERFLOW_BIT = 19;
  localparam int ST_EN_BIT       = 20;

  localparam int LOWWATER_RST = 16;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_CTRL,
    SEL_LOWWATER,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [3:0] a);
    reg_sel_e sel;
    case (a)
      REG_DATA:     sel = SEL_DATA;
      REG_CTRL:     sel = SEL_CTRL;
      REG_LOWWATER: sel = SEL_LOWWATER;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pcm_stream_fifo_sync_fifo.sv
// Single-clock circular buffer with push/pop/flush, level and full/empty.
// A push into a full buffer is still taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  push_ok_o
);

  localparam logic [DEPTH_LOG2:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == DEPTH_L);
  assign pop_ok    = pop_i && !empty_o && !flush_i;
  assign push_ok   = push_i && !flush_i && (!full_o || pop_ok);
  assign push_ok_o = push_ok;
  assign head_o    = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset: an empty level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pcm_stream_fifo.sv
// CPU-fed PCM sample streamer: bus decode, sample tick, sticky flags, pcm_out and irq.
// Optional low-water interrupt is built when PCM_STREAM_IRQ_EN is defined.
module pcm_stream_fifo
  import pcm_stream_pkg::*;
#(
  parameter int DEPTH_LOG2      = 6,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int SAMPLECLOCK_DIV = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              addr,
  input  logic [31:0]             data_in,
  input  logic                    wen,
  input  logic                    ren,
  output logic [31:0]             data_out,
  output logic                    ready,
  output logic [SAMPLE_WIDTH-1:0] pcm_out,
  output logic                    irq
);

  localparam int LW = DEPTH_LOG2 + 1;

  logic [SAMPLECLOCK_DIV-1:0] cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic [31:0]                data_out_q, data_out_d;
  logic                       enable_q, enable_d;
  logic [LW-1:0]              lowwater_q, lowwater_d;
  logic                       underrun_q, underrun_d;
  logic                       overflow_q, overflow_d;
  logic [SAMPLE_WIDTH-1:0]    pcm_q, pcm_d;

  logic                    req, access, wr_acc, rd_acc;
  reg_sel_e                sel;
  logic                    push, ctrl_wr, flush, clr, disable_wr;
  logic                    tick, pop_req;
  logic [SAMPLE_WIDTH-1:0] head;
  logic [LW-1:0]           level;
  logic                    empty, full, push_ok;
  logic [31:0]             status;
  logic                    unused_ok;

  assign unused_ok = ^data_in;

  // One action per strobe: only the first cycle of a request (ready_q low) acts.
  assign req        = wen || ren;
  assign access     = req && !ready_q;
  assign wr_acc     = access && wen;
  assign rd_acc     = access && ren && !wen;
  assign sel        = decode_addr(addr);
  assign push       = wr_acc && (sel == SEL_DATA);
  assign ctrl_wr    = wr_acc && (sel == SEL_CTRL);
  assign flush      = ctrl_wr && data_in[CTRL_FLUSH_BIT];
  assign clr        = ctrl_wr && data_in[CTRL_CLR_BIT];
  assign disable_wr = ctrl_wr && enable_q && !data_in[CTRL_EN_BIT];
  assign tick       = &cnt_q;
  assign pop_req    = tick && enable_q && !flush && !disable_wr;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (SAMPLE_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .data_i    (data_in[SAMPLE_WIDTH-1:0]),
    .pop_i     (pop_req),
    .flush_i   (flush),
    .head_o    (head),
    .level_o   (level),
    .empty_o   (empty),
    .full_o    (full),
    .push_ok_o (push_ok)
  );

  always_comb begin
    status                  = '0;
    status[LW-1:0]          = level;
    status[ST_EMPTY_BIT]    = empty;
    status[ST_FULL_BIT]     = full;
    status[ST_UNDERRUN_BIT] = underrun_q;
    status[ST_OVERFLOW_BIT] = overflow_q;
    status[ST_EN_BIT]       = enable_q;
  end

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    ready_d    = access;
    data_out_d = data_out_q;
    enable_d   = enable_q;
    lowwater_d = lowwater_q;
    pcm_d      = pcm_q;

    if (rd_acc) begin
      case (sel)
        SEL_CTRL:     data_out_d = status;
        SEL_LOWWATER: data_out_d = 32'(lowwater_q);
        default:      data_out_d = '0;
      endcase
    end

    if (ctrl_wr) enable_d = data_in[CTRL_EN_BIT];
    if (wr_acc && (sel == SEL_LOWWATER)) lowwater_d = data_in[LW-1:0];

    // Set wins over a same-cycle clear.
    underrun_d = (underrun_q && !clr) || (pop_req && empty);
    overflow_d = (overflow_q && !clr) || (push && !push_ok);

    if (disable_wr) begin
      pcm_d = '0;
    end else if (pop_req) begin
      pcm_d = empty ? '0 : head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      enable_q   <= 1'b0;
      lowwater_q <= LW'(LOWWATER_RST);
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      pcm_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      enable_q   <= enable_d;
      lowwater_q <= lowwater_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      pcm_q      <= pcm_d;
    end
  end

  assign ready    = ready_q && req;
  assign data_out = data_out_q;
  assign pcm_out  = pcm_q;

`ifdef PCM_STREAM_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= enable_q && (level <= lowwater_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/pcm_stream_fifo.md
Name: pcm_stream_fifo

Overview:
CPU-fed PCM sample streamer that sits directly upstream of the synth mixer's PCM input.
- Firmware pushes signed 16-bit samples over the memory bus into a FIFO.
- The block pops one sample per sample tick and holds it on pcm_out, which feeds the mixer summing node in place of the static PCM register.
- Provides status readback, sticky error flags and an optional low-water interrupt.

Parameters:
DEPTH_LOG2, 6, FIFO depth = 2**DEPTH_LOG2 entries (64)
SAMPLE_WIDTH, 16, bits per stored/output sample
SAMPLECLOCK_DIV, 10, sample tick every 2**SAMPLECLOCK_DIV clk cycles (46,875 Hz at 48 MHz)

Ports:
clk  in  1  system clock, 48 MHz
rst  in  1  synchronous, active-high reset
addr  in  4  register byte offset (word-aligned: 0x0, 0x4, 0x8)
data_in  in  32  write data
wen  in  1  write strobe, held until ready
ren  in  1  read strobe, held until ready
data_out  out  32  read data, valid while ready && ren
ready  out  1  bus acknowledge
pcm_out  out  SAMPLE_WIDTH  current sample to mixer
irq  out  1  low-water interrupt, level

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-high on rst; every register clears when rst is high at a clk edge.
- Reset values:
  - pcm_out=0, irq=0, ready=0, data_out=0
  - FIFO empty, enable=0, lowwater=16, sticky flags=0, tick counter=0
- Sample tick:
  - Free-running counter of SAMPLECLOCK_DIV bits.
  - tick is high for one cycle when the counter equals all-ones.
- Bus handshake:
  - ready_q<=1 in the cycle after a wen or ren is seen with ready_q=0; otherwise ready_q<=0.
  - ready = ready_q && (wen||ren).
  - Each access has exactly one action per strobe assertion, taken at the first cycle of the strobe (ready_q=0).
- Register map:
  - 0x0 write: push data_in[15:0].
  - 0x0 read: returns 0.
  - 0x4 write: bit0 enable; bit1 flush (self-clearing, empties FIFO); bit2 clear sticky flags.
  - 0x4 read: [DEPTH_LOG2:0] level, bit16 empty, bit17 full, bit18 underrun, bit19 overflow, bit20 enable.
  - 0x8 write/read: lowwater[DEPTH_LOG2:0].
- Push:
  - Accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise dropped and overflow<=1.
- Pop, on tick && enable:
  - If level>0: pcm_out<=head, pointer advances.
  - If empty: pcm_out<=0, underrun<=1.
- Enable=0:
  - No pops; pcm_out holds its last value.
  - Writing enable 1->0 forces pcm_out<=0 next cycle.
- Flush, write-to-0x4 with bit1:
  - Pointers reset and level=0.
  - Takes priority over a same-cycle pop; pcm_out unchanged.
- Level bookkeeping:
  - level is DEPTH_LOG2+1 bits.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves level unchanged.
- Sticky flag clear: clear-sticky in the same cycle as a new error event leaves the flag set (set wins).
- Reset mid-stream discards all FIFO contents; no partial bus acknowledge is issued.

Optional Feature:
PCM_STREAM_IRQ_EN
- Defined: irq registered, irq<=enable && (level<=lowwater); it deasserts in the cycle after level rises above lowwater.
- Undefined: irq tied 0; register 0x8 still reads and writes but has no effect.

Decomposition:
- Shared package pcm_stream_pkg holds:
  - register offsets REG_DATA=0x0, REG_CTRL=0x4, REG_LOWWATER=0x8
  - CTRL/STATUS bit-position constants
  - the reset lowwater default
- Natural sub-module: sync_fifo (single-clock circular buffer, push/pop/flush, level, full/empty).
- pcm_stream_fifo contains bus decode, tick generator, flags and irq.

Test Plan:
- Reset, then read 0x4 -> 0x00010000 (empty=1, level=0); pcm_out=0; irq=0.
- Push 0x1234, 0xABCD; enable=1 -> first tick pcm_out=0x1234, second 0xABCD, third 0x0000 with underrun=1.
- Push 65 samples, enable=0 -> level=64, full=1, overflow=1; sample #65 absent on drain.
- With FIFO full, force push coincident with tick -> push accepted, level stays 64, overflow stays 0.
- Level 20, write flush in a tick cycle -> level=0, pcm_out unchanged; write clear-sticky -> bits 18/19 = 0.
- With PCM_STREAM_IRQ_EN: lowwater=4, drain from 6 -> irq rises the cycle after level hits 4; pushing to 5 drops irq; irq=0 if enable=0.
